// File: rtl/cfg_writer.sv
// Collects a frame of network beats and hands it to config memory.
// An ack timeout parks the block in ERROR until software clears it.
module cfg_writer #(
    parameter int width       = 16,
    parameter int num_inputs  = 8,
    parameter int ack_timeout = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             net_valid,
    input  logic [width-1:0]                 net_data,
    output logic                             net_ready,
    input  logic                             write_rdy,
    output logic                             write_en,
    output logic [num_inputs:0][width-1:0]   w_data_out,
    input  logic                             write_ack,
    input  logic                             clear_err,
    output logic                             err,
    output logic [7:0]                       frame_count
);

    localparam int IW = (num_inputs < 1) ? 1 : $clog2(num_inputs + 1);
    localparam int TW = (ack_timeout < 2) ? 1 : $clog2(ack_timeout);

    typedef enum logic [1:0] {
        COLLECT,
        WAIT_RDY,
        WRITE,
        ERROR
    } state_t;

    state_t                           state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [TW-1:0]                    cnt_q, cnt_d;
    logic [7:0]                       fc_q, fc_d;
    logic [num_inputs:0][width-1:0]   data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            cnt_q   <= '0;
            fc_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        data_d  = data_q;
        unique case (state_q)
            COLLECT: begin
                if (net_valid) begin
                    data_d[idx_q] = net_data;
                    if (idx_q == IW'(num_inputs)) begin
                        idx_d   = '0;
                        state_d = WAIT_RDY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT_RDY: begin
                if (write_rdy) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                // An ack on the final allowed cycle still counts as success
                if (write_ack) begin
                    state_d = COLLECT;
                    fc_d    = fc_q + 8'd1;
                end else if (cnt_q == TW'(ack_timeout - 1)) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERROR: begin
                if (clear_err) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign net_ready   = (state_q == COLLECT);
    assign write_en    = (state_q == WRITE);
    assign err         = (state_q == ERROR);
    assign frame_count = fc_q;
    assign w_data_out  = data_q;

endmodule

// File: tb/tb_cfg_writer.sv
// Randomized scoreboard bench for cfg_writer.
// Driver pushes expected frames/counts; a negedge monitor checks them.
module tb_cfg_writer;

    localparam int W  = 16;
    localparam int NI = 8;
    localparam int TO = 64;

    typedef logic [NI:0][W-1:0] frame_t;

    logic                 clk;
    logic                 reset;
    logic                 net_valid;
    logic [W-1:0]         net_data;
    logic                 net_ready;
    logic                 write_rdy;
    logic                 write_en;
    frame_t               w_data_out;
    logic                 write_ack;
    logic                 clear_err;
    logic                 err;
    logic [7:0]           frame_count;

    cfg_writer #(.width(W), .num_inputs(NI), .ack_timeout(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .net_valid   (net_valid),
        .net_data    (net_data),
        .net_ready   (net_ready),
        .write_rdy   (write_rdy),
        .write_en    (write_en),
        .w_data_out  (w_data_out),
        .write_ack   (write_ack),
        .clear_err   (clear_err),
        .err         (err),
        .frame_count (frame_count)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    frame_t     cur;
    int         nb;
    logic [7:0] mfc;
    frame_t     exp_frames[$];
    logic [7:0] exp_fc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_beat(input logic [W-1:0] d);
        cur[nb] = d;
        nb++;
        if (nb == NI + 1) begin
            exp_frames.push_back(cur);
            nb = 0;
        end
    endtask

    // monitor: frame on write_en rise, stability in WRITE, count changes
    logic       prev_we = 1'b0;
    logic [7:0] prev_fc = 8'd0;
    frame_t     snap;
    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
            prev_fc = frame_count;
        end else begin
            if (write_en && !prev_we) begin
                if (exp_frames.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    chk("frame_data", w_data_out, exp_frames.pop_front());
                end
                snap = w_data_out;
            end else if (write_en) begin
                chk("frame_stable", w_data_out, snap);
            end
            if (frame_count != prev_fc) begin
                if (exp_fc.size() == 0) chk("unexpected_count", frame_count, prev_fc);
                else chk("frame_count", frame_count, exp_fc.pop_front());
            end
            prev_we = write_en;
            prev_fc = frame_count;
        end
    end

    task automatic beat(input logic [W-1:0] d, input int gap);
        repeat (gap) @(negedge clk);
        net_valid = 1'b1;
        net_data  = d;
        for (int t = 0; t < 200 && !net_ready; t++) @(negedge clk);
        if (!net_ready) chk("beat_wait", 0, 1);
        model_beat(d);
        @(negedge clk);
        net_valid = 1'b0;
    endtask

    task automatic rand_frame(input int maxgap);
        for (int i = 0; i <= NI; i++)
            beat(W'($urandom), int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_write(input int rdy_delay, input int k,
                            input bit early, input logic [W-1:0] ed);
        int   hi;
        logic blocked;
        hi = 0;
        blocked = 1'b1;
        if (early) begin
            net_valid = 1'b1;
            net_data  = ed;
        end
        repeat (rdy_delay) begin
            write_ack = 1'($urandom);
            clear_err = 1'($urandom);
            if (early && net_ready) blocked = 1'b0;
            @(negedge clk);
        end
        write_ack = 1'b0;
        clear_err = 1'b0;
        write_rdy = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= k; c++) begin
            write_rdy = 1'($urandom);
            write_ack = (c == k);
            if (c == k) begin
                mfc++;
                exp_fc.push_back(mfc);
            end
            if (write_en) hi++;
            if (early && net_ready) blocked = 1'b0;
            @(negedge clk);
        end
        write_ack = 1'b0;
        write_rdy = 1'b0;
        chk("we_cycles", hi, k);
        chk("we_drop", write_en, 0);
        if (early) begin
            chk("early_blocked", blocked, 1);
            chk("early_ready", net_ready, 1);
            model_beat(ed);
            @(negedge clk);
            net_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_write_en", write_en, 0);
        chk("rst_err", err, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_data", w_data_out, 0);
        chk("rst_ready", net_ready, 1);
        nb  = 0;
        cur = '0;
        mfc = 8'd0;
        net_valid = 1'b0;
        write_rdy = 1'b0;
        write_ack = 1'b0;
        clear_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        net_valid = 1'b0;
        net_data  = '0;
        write_rdy = 1'b0;
        write_ack = 1'b0;
        clear_err = 1'b0;
        nb  = 0;
        cur = '0;
        mfc = 8'd0;
        do_reset();

        // nine sequential beats, ack two cycles after write_rdy
        for (int i = 1; i <= NI + 1; i++) beat(W'(i), 0);
        do_write(0, 2, 1'b0, '0);
        chk("first_count", frame_count, 1);
        chk("word0", w_data_out[0], 16'h0001);
        chk("word8", w_data_out[NI], 16'h0009);

        // gaps, with the next frame's first beat offered early
        rand_frame(3);
        do_write(3, 5, 1'b1, 16'hBEEF);
        for (int i = 1; i <= NI; i++) beat(W'($urandom), int'($urandom_range(0, 2)));
        do_write(1, 3, 1'b0, '0);

        // ack never arrives
        rand_frame(1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_ignored", net_ready, 0);
        write_rdy = 1'b1;
        @(negedge clk);
        write_rdy = 1'b0;
        hi = 0;
        repeat (TO + 6) begin
            if (write_en) hi++;
            @(negedge clk);
        end
        chk("timeout_cycles", hi, TO);
        chk("timeout_err", err, 1);
        chk("timeout_ready", net_ready, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("cleared_err", err, 0);
        chk("cleared_ready", net_ready, 1);
        chk("cleared_count", frame_count, mfc);

        // ack on the last allowed cycle
        rand_frame(0);
        do_write(0, TO, 1'b0, '0);
        chk("late_ack_err", err, 0);

        repeat (20) begin
            rand_frame(2);
            do_write(int'($urandom_range(0, 4)), int'($urandom_range(1, TO)),
                     1'($urandom), W'($urandom));
            if (nb != 0) begin
                for (int i = nb; i <= NI; i++) beat(W'($urandom), 0);
                do_write(0, 1, 1'b0, '0);
            end
        end

        // count wrap after 256 frames
        do_reset();
        repeat (256) begin
            rand_frame(0);
            do_write(0, 1, 1'b0, '0);
        end
        chk("wrap_count", frame_count, 0);

        // reset mid-frame, then a frame must restart at word 0
        for (int i = 0; i < 4; i++) beat(W'($urandom), 0);
        do_reset();
        rand_frame(1);
        do_write(2, 4, 1'b0, '0);

        // reset while writing drops write_en at once
        rand_frame(0);
        write_rdy = 1'b1;
        @(negedge clk);
        write_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_we", write_en, 1);
        do_reset();

        repeat (3) @(negedge clk);
        chk("frames_drained", exp_frames.size(), 0);
        chk("counts_drained", exp_fc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
